// File: rtl/ps2_keycode_receiver_if.sv
// Signal bundle between a PS/2 line source and the keycode receiver.
// master drives the raw PS/2 lines; slave is the receiver presenting key events and its FSM state.
interface ps2_keycode_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyCode;
    logic       keyValid;
    logic       keyExt;
    logic       frameErr;
    logic [1:0] state;

    // No back-pressure: keyValid/keyCode/keyExt and frameErr are single-cycle pulses
    // that the consumer must sample every cycle; there is no ready signal.
    modport master (
        output ps2_clk, ps2_data,
        input  keyCode, keyValid, keyExt, frameErr, state
    );
    modport slave (
        input  ps2_clk, ps2_data,
        output keyCode, keyValid, keyExt, frameErr, state
    );
endinterface

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard frame receiver emitting one-cycle make-code pulses, with E0/F0 prefix handling.
// Optional macro PS2_REPEAT_FILTER_EN drops typematic repeats of the currently held key.
module ps2_keycode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic clk,
    input logic rst,
    ps2_keycode_receiver_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic          fall, timeout;

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic       par, par_n;
    logic       ext_pend, ext_n;
    logic       brk_pend, brk_n;
    logic [7:0] code_q, code_n;
    logic       valid_q, valid_n;
    logic       kext_q, kext_n;
    logic       err_q, err_n;
    logic       accept;

    // Input path: synchronizers, clock glitch filter, edge detect, stall timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
            tcnt   <= '0;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
            filt_d <= filt;
            if (clk_s2 != filt) begin
                if (fcnt == FLIM) begin
                    filt <= clk_s2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
            if (state == IDLE || fall) tcnt <= '0;
            else if (tcnt != TLIM)     tcnt <= tcnt + 1'b1;
        end
    end

    assign fall    = filt_d & ~filt;
    assign timeout = (state != IDLE) && (tcnt == TLIM);

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] held_code, held_code_n;
    logic       held_ext, held_ext_n;
    logic       held_vld, held_vld_n;
    logic       held_hit;
    assign held_hit = held_vld && (held_code == shift) && (held_ext == ext_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
        end else begin
            held_code <= held_code_n;
            held_ext  <= held_ext_n;
            held_vld  <= held_vld_n;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bitcnt   <= '0;
            par      <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            kext_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bitcnt   <= bitcnt_n;
            par      <= par_n;
            ext_pend <= ext_n;
            brk_pend <= brk_n;
            code_q   <= code_n;
            valid_q  <= valid_n;
            kext_q   <= kext_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        par_n    = par;
        ext_n    = ext_pend;
        brk_n    = brk_pend;
        code_n   = 8'h00;
        valid_n  = 1'b0;
        kext_n   = 1'b0;
        err_n    = 1'b0;
        accept   = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        held_code_n = held_code;
        held_ext_n  = held_ext;
        held_vld_n  = held_vld;
`endif
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                DATA: begin
                    shift_n  = {dat_s2, shift[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if ((^{shift, par}) && dat_s2) accept = 1'b1;
                    else                           err_n  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end

        if (accept) begin
            if (shift == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shift == 8'hF0) begin
                brk_n = 1'b1;
            end else if (brk_pend) begin
                ext_n = 1'b0;
                brk_n = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                if (held_hit) held_vld_n = 1'b0;
`endif
            end else begin
                ext_n = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                if (!held_hit) begin
                    code_n      = shift;
                    valid_n     = 1'b1;
                    kext_n      = ext_pend;
                    held_code_n = shift;
                    held_ext_n  = ext_pend;
                    held_vld_n  = 1'b1;
                end
`else
                code_n  = shift;
                valid_n = 1'b1;
                kext_n  = ext_pend;
`endif
            end
        end

        // A framing error discards any partially received prefix sequence.
        if (err_n) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            held_vld_n = 1'b0;
`endif
        end
    end

    assign bus.keyCode  = code_q;
    assign bus.keyValid = valid_q;
    assign bus.keyExt   = kext_q;
    assign bus.frameErr = err_q;
    assign bus.state    = state;
endmodule
